// File: rtl/dwt97_lift_unit_mc_pkg.sv
// Shared definitions for the DWT97 lifting pair unit: default 9/7 coefficients (Q16),
// line-state encoding and the saturating adder used by every lifting step.
package dwt97_lift_unit_mc_pkg;

    // CDF 9/7 predict/update coefficients scaled by 2^16
    localparam int ALPHA_Q16 = -103949;
    localparam int BETA_Q16  = -3472;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FLUSH
    } line_state_e;

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/dwt97_lift_unit_mc_mac.sv
// One registered lifting step r = sat(a + (c*(x+y)) >> Point).
// DWT97_ROUND_EN adds half an LSB before the shift (round half up); otherwise floor.
module dwt97_lift_mac
    import dwt97_lift_unit_mc_pkg::*;
#(
    parameter int DataWidth  = 24,
    parameter int Point      = 16,
    parameter int CoeffWidth = 20
) (
    input  logic                         clk_i,
    input  logic                         en_i,
    input  logic signed [CoeffWidth-1:0] coef_i,
    input  logic signed [DataWidth-1:0]  a_i,
    input  logic signed [DataWidth-1:0]  x_i,
    input  logic signed [DataWidth-1:0]  y_i,
    output logic signed [DataWidth-1:0]  r_o
);

    localparam int SumW  = DataWidth + 1;
    localparam int ProdW = SumW + CoeffWidth;

    logic signed [SumW-1:0]      sum;
    logic signed [ProdW-1:0]     prod;
    logic signed [ProdW-1:0]     scaled;
    logic signed [DataWidth-1:0] r_q;

    function automatic logic signed [ProdW-1:0] scale_q(input logic signed [ProdW-1:0] p);
`ifdef DWT97_ROUND_EN
        localparam logic signed [ProdW-1:0] Half = ProdW'(1) <<< (Point - 1);
        return (p + Half) >>> Point;
`else
        return p >>> Point;
`endif
    endfunction

    assign sum    = SumW'(x_i) + SumW'(y_i);
    assign prod   = ProdW'(sum) * ProdW'(coef_i);
    assign scaled = scale_q(prod);

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_q <= DataWidth'(sat_add(64'(a_i), 64'(scaled), DataWidth));
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/dwt97_lift_unit_mc.sv
// Multi-lane row-mode 9/7 predict+update pair with symmetric line ends and valid/ready flow.
// Optional rounding in the lifting steps is selected by DWT97_ROUND_EN.
module dwt97_lift_unit_mc
    import dwt97_lift_unit_mc_pkg::*;
#(
    parameter int                          DataWidth  = 24,
    parameter int                          Point      = 16,
    parameter int                          CoeffWidth = 20,
    parameter int                          Lanes      = 1,
    parameter logic signed [CoeffWidth-1:0] Alpha     = CoeffWidth'(ALPHA_Q16),
    parameter logic signed [CoeffWidth-1:0] Beta      = CoeffWidth'(BETA_Q16)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    output logic                           s_ready_o,
    input  logic                           s_valid_i,
    input  logic                           s_sof_i,
    input  logic                           s_eol_i,
    input  logic [2*DataWidth*Lanes-1:0]   s_data_i,
    input  logic                           m_ready_i,
    output logic                           m_valid_o,
    output logic                           m_sof_o,
    output logic                           m_eol_o,
    output logic [2*DataWidth*Lanes-1:0]   m_data_o
);

    localparam int PairW = 2 * DataWidth;

    line_state_e state_q;
    logic        pend_q, first_hold_q, sof_hold_q;
    logic        en, flush, acc, line_start, from_input;
    logic        issue, issue_sof, issue_eol, issue_first;

    logic signed [DataWidth-1:0] in_ev [Lanes];
    logic signed [DataWidth-1:0] in_od [Lanes];
    logic signed [DataWidth-1:0] ev_hold_q [Lanes];
    logic signed [DataWidth-1:0] od_hold_q [Lanes];
    logic signed [DataWidth-1:0] issue_ev [Lanes];
    logic signed [DataWidth-1:0] issue_od [Lanes];
    logic signed [DataWidth-1:0] issue_evn [Lanes];

    logic signed [DataWidth-1:0] ev_p0_q [Lanes];
    logic signed [DataWidth-1:0] od_p0_q [Lanes];
    logic signed [DataWidth-1:0] evn_p0_q [Lanes];
    logic                        vld_p0_q, sof_p0_q, eol_p0_q, first_p0_q;

    logic signed [DataWidth-1:0] h_p1 [Lanes];
    logic signed [DataWidth-1:0] ev_p1_q [Lanes];
    logic signed [DataWidth-1:0] h_prev_q [Lanes];
    logic signed [DataWidth-1:0] upd_x [Lanes];
    logic                        vld_p1_q, sof_p1_q, eol_p1_q, first_p1_q;

    logic signed [DataWidth-1:0] l_p2 [Lanes];
    logic signed [DataWidth-1:0] h_p2_q [Lanes];
    logic                        vld_p2_q, sof_p2_q, eol_p2_q;

    logic                        m_valid_q, m_sof_q, m_eol_q;
    logic [2*DataWidth*Lanes-1:0] m_data_q;

    assign en         = !m_valid_q || m_ready_i;
    assign flush      = (state_q == ST_FLUSH);
    assign s_ready_o  = en && !flush && !rst_i;
    assign acc        = s_valid_i && s_ready_o;
    assign line_start = s_sof_i || (state_q == ST_IDLE);

    // Issue select: held pair (normal/flush) or the incoming pair for a single-pair line
    always_comb begin
        from_input  = acc && line_start && s_eol_i;
        issue       = flush ? pend_q : (acc && (!line_start || s_eol_i));
        issue_sof   = from_input ? s_sof_i : sof_hold_q;
        issue_eol   = flush || from_input;
        issue_first = from_input || first_hold_q;
        for (int j = 0; j < Lanes; j++) begin
            in_ev[j]     = s_data_i[PairW*j +: DataWidth];
            in_od[j]     = s_data_i[PairW*j + DataWidth +: DataWidth];
            issue_ev[j]  = from_input ? in_ev[j] : ev_hold_q[j];
            issue_od[j]  = from_input ? in_od[j] : od_hold_q[j];
            issue_evn[j] = flush ? ev_hold_q[j] : in_ev[j];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pend_q       <= 1'b0;
            first_hold_q <= 1'b0;
            sof_hold_q   <= 1'b0;
            vld_p0_q     <= 1'b0;
            sof_p0_q     <= 1'b0;
            eol_p0_q     <= 1'b0;
            first_p0_q   <= 1'b0;
            vld_p1_q     <= 1'b0;
            sof_p1_q     <= 1'b0;
            eol_p1_q     <= 1'b0;
            first_p1_q   <= 1'b0;
            vld_p2_q     <= 1'b0;
            sof_p2_q     <= 1'b0;
            eol_p2_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            m_data_q     <= '0;
        end else if (en) begin
            // p0: operands issued
            vld_p0_q   <= issue;
            sof_p0_q   <= issue && issue_sof;
            eol_p0_q   <= issue && issue_eol;
            first_p0_q <= issue_first;
            // p1: predict result
            vld_p1_q   <= vld_p0_q;
            sof_p1_q   <= sof_p0_q;
            eol_p1_q   <= eol_p0_q;
            first_p1_q <= first_p0_q;
            // p2: update result
            vld_p2_q   <= vld_p1_q;
            sof_p2_q   <= sof_p1_q;
            eol_p2_q   <= eol_p1_q;
            // output register
            m_valid_q  <= vld_p2_q;
            m_sof_q    <= sof_p2_q;
            m_eol_q    <= eol_p2_q;
            if (vld_p2_q) begin
                for (int j = 0; j < Lanes; j++) begin
                    m_data_q[PairW*j +: PairW] <= {h_p2_q[j], l_p2[j]};
                end
            end
            case (state_q)
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                    pend_q  <= 1'b0;
                end
                default: begin
                    if (acc) begin
                        state_q      <= s_eol_i ? ST_FLUSH : ST_HOLD;
                        pend_q       <= s_eol_i && !line_start;
                        first_hold_q <= line_start;
                        sof_hold_q   <= line_start && s_sof_i;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            for (int j = 0; j < Lanes; j++) begin
                if (acc) begin
                    ev_hold_q[j] <= in_ev[j];
                    od_hold_q[j] <= in_od[j];
                end
                ev_p0_q[j]  <= issue_ev[j];
                od_p0_q[j]  <= issue_od[j];
                evn_p0_q[j] <= issue_evn[j];
                ev_p1_q[j]  <= ev_p0_q[j];
                h_p2_q[j]   <= h_p1[j];
                // left neighbour of the next high sample; line start mirrors h_0 instead
                if (vld_p1_q) begin
                    h_prev_q[j] <= h_p1[j];
                end
            end
        end
    end

    for (genvar j = 0; j < Lanes; j++) begin : g_lane
        dwt97_lift_mac #(
            .DataWidth (DataWidth),
            .Point     (Point),
            .CoeffWidth(CoeffWidth)
        ) u_predict (
            .clk_i (clk_i),
            .en_i  (en),
            .coef_i(Alpha),
            .a_i   (od_p0_q[j]),
            .x_i   (ev_p0_q[j]),
            .y_i   (evn_p0_q[j]),
            .r_o   (h_p1[j])
        );

        assign upd_x[j] = first_p1_q ? h_p1[j] : h_prev_q[j];

        dwt97_lift_mac #(
            .DataWidth (DataWidth),
            .Point     (Point),
            .CoeffWidth(CoeffWidth)
        ) u_update (
            .clk_i (clk_i),
            .en_i  (en),
            .coef_i(Beta),
            .a_i   (ev_p1_q[j]),
            .x_i   (upd_x[j]),
            .y_i   (h_p1[j]),
            .r_o   (l_p2[j])
        );
    end

    assign m_valid_o = m_valid_q;
    assign m_sof_o   = m_sof_q;
    assign m_eol_o   = m_eol_q;
    assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_dwt97_lift_unit_mc.sv
// Scoreboard bench for dwt97_lift_unit_mc (3 lanes, Alpha=-0.5, Beta=0.25 in Q16).
module tb_dwt97_lift_unit_mc;

    localparam int DW   = 24;
    localparam int L    = 3;
    localparam int BUSW = 2 * DW * L;

    typedef struct packed {
        logic            sof;
        logic            eol;
        logic [BUSW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            s_ready_o, s_valid_i, s_sof_i, s_eol_i;
    logic [BUSW-1:0] s_data_i;
    logic            m_ready_i, m_valid_o, m_sof_o, m_eol_o;
    logic [BUSW-1:0] m_data_o;

    exp_t exq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b1;
    bit   bp_en   = 1'b0;

    longint t5_ev [L][16];
    longint t5_od [L][16];
    longint t5_h  [L][16];
    longint t5_l  [L][16];

    always #5 clk = ~clk;

    dwt97_lift_unit_mc #(
        .DataWidth (24),
        .Point     (16),
        .CoeffWidth(20),
        .Lanes     (L),
        .Alpha     (-20'sd32768),
        .Beta      (20'sd16384)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .s_ready_o(s_ready_o),
        .s_valid_i(s_valid_i),
        .s_sof_i  (s_sof_i),
        .s_eol_i  (s_eol_i),
        .s_data_i (s_data_i),
        .m_ready_i(m_ready_i),
        .m_valid_o(m_valid_o),
        .m_sof_o  (m_sof_o),
        .m_eol_o  (m_eol_o),
        .m_data_o (m_data_o)
    );

    function automatic logic [BUSW-1:0] pk(input int a0, input int b0,
                                           input int a1 = 0, input int b1 = 0,
                                           input int a2 = 0, input int b2 = 0);
        return {24'(a2), 24'(b2), 24'(a1), 24'(b1), 24'(a0), 24'(b0)};
    endfunction

    // Reference lifting step on plain integers: a + (c*(x+y)) >> 16, saturated to 24 bits
    function automatic longint step(input longint a, input longint x, input longint y, input longint c);
        longint p;
        p = (x + y) * c;
`ifdef DWT97_ROUND_EN
        p = p + 32768;
`endif
        p = p >>> 16;
        p = a + p;
        if (p > 8388607) p = 8388607;
        if (p < -8388608) p = -8388608;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input bit sof, input bit eol, input logic [BUSW-1:0] d);
        exp_t e;
        e.sof  = sof;
        e.eol  = eol;
        e.data = d;
        exq.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send(input bit sof, input bit eol, input logic [BUSW-1:0] d);
        int n;
        s_valid_i = 1'b1;
        s_sof_i   = sof;
        s_eol_i   = eol;
        s_data_i  = d;
        #1;
        n = 0;
        while (!s_ready_o && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: s_ready_o stayed %0b, required 1", s_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exq.size() != 0; i++) @(negedge clk);
        if (exq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exq.size());
            exq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_en) begin
                for (int i = 0; i < 4 && bp_en; i++) begin
                    m_ready_i = (i == 0 || i == 3);
                    if (i < 3) @(negedge clk);
                end
            end else begin
                m_ready_i = 1'b1;
            end
        end
    end

    // Monitor: a beat transfers on the next rising edge when valid and ready are both high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_i && chk_en && m_valid_o && m_ready_i) begin
                n_tests++;
                if (exq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got sof=%0b eol=%0b data=%h, required no beat",
                             m_sof_o, m_eol_o, m_data_o);
                end else begin
                    e = exq.pop_front();
                    if ({m_sof_o, m_eol_o, m_data_o} !== {e.sof, e.eol, e.data}) begin
                        n_fail++;
                        $display("FAIL beat: got sof=%0b eol=%0b data=%h, required sof=%0b eol=%0b data=%h",
                                 m_sof_o, m_eol_o, m_data_o, e.sof, e.eol, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUSW-1:0] d;
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_sof_i   = 1'b0;
        s_eol_i   = 1'b0;
        s_data_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_s_ready", 64'(s_ready_o), 64'd0);
        check("reset_m_valid", 64'(m_valid_o), 64'd0);
        check("reset_m_data", 64'(m_data_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Basic N=2 line, latency and flush bubble
        push(1'b1, 1'b0, pk(-131072, 196608));
        push(1'b0, 1'b1, pk(65536, 114688));
        send(1'b1, 1'b0, pk(65536, 262144));
        send(1'b0, 1'b1, pk(196608, 131072));
        #1;
        check("t1_flush_ready", 64'(s_ready_o), 64'd0);
        check("t1_valid_e0", 64'(m_valid_o), 64'd0);
        @(negedge clk); #1;
        check("t1_ready_back", 64'(s_ready_o), 64'd1);
        @(negedge clk); #1;
        check("t1_valid_e2", 64'(m_valid_o), 64'd0);
        @(negedge clk); #1;
        check("t1_valid_e3", 64'(m_valid_o), 64'd1);
        @(negedge clk);
        wait_drain();

        // Rounding of a half-LSB predict term
`ifdef DWT97_ROUND_EN
        push(1'b1, 1'b0, pk(0, 1));
        push(1'b0, 1'b1, pk(0, 0));
`else
        push(1'b1, 1'b0, pk(-1, 0));
        push(1'b0, 1'b1, pk(0, -1));
`endif
        send(1'b1, 1'b0, pk(0, 1));
        send(1'b0, 1'b1, pk(0, 0));
        wait_drain();

        // Saturation of the predict sum, both polarities
`ifdef DWT97_ROUND_EN
        push(1'b1, 1'b1, pk(8388607, -2359296));
`else
        push(1'b1, 1'b1, pk(8388607, -2359297));
`endif
        push(1'b1, 1'b1, pk(-8388608, 2359296));
        send(1'b1, 1'b1, pk(6553600, -6553600));
        @(negedge clk);
        send(1'b1, 1'b1, pk(-6553600, 6553600));
        wait_drain();

        // N=1 line: eol on the first beat, latency 3 and a flush bubble
        push(1'b1, 1'b1, pk(-131072, 65536));
        send(1'b1, 1'b1, pk(0, 131072));
        #1;
        check("t4_flush_ready", 64'(s_ready_o), 64'd0);
        @(negedge clk);
        @(negedge clk); #1;
        check("t4_valid_e2", 64'(m_valid_o), 64'd0);
        @(negedge clk); #1;
        check("t4_valid_e3", 64'(m_valid_o), 64'd1);
        @(negedge clk);
        wait_drain();

        // 16-pair line, 3 distinct lanes, backpressure 1,0,0,1 and one input bubble
        for (int j = 0; j < L; j++) begin
            for (int k = 0; k < 16; k++) begin
                t5_ev[j][k] = longint'((k * 37 + j * 91) % 200 - 100) * 1000;
                t5_od[j][k] = longint'((k * 53 + j * 29) % 160 - 80) * 1500;
            end
            for (int k = 0; k < 16; k++)
                t5_h[j][k] = step(t5_od[j][k], t5_ev[j][k], t5_ev[j][(k == 15) ? 15 : k + 1], -32768);
            for (int k = 0; k < 16; k++)
                t5_l[j][k] = step(t5_ev[j][k], t5_h[j][(k == 0) ? 0 : k - 1], t5_h[j][k], 16384);
        end
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < L; j++) d[48*j +: 48] = {24'(t5_h[j][k]), 24'(t5_l[j][k])};
            push(k == 0, k == 15, d);
        end
        bp_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < L; j++) d[48*j +: 48] = {24'(t5_od[j][k]), 24'(t5_ev[j][k])};
            send(k == 0, k == 15, d);
            if (k == 7) @(negedge clk);
        end
        wait_drain();
        bp_en = 1'b0;
        repeat (4) @(negedge clk);

        // sof restart after 5 unterminated pairs: pair 4 is dropped
        push(1'b1, 1'b0, pk(-65536, 98304));
        for (int k = 1; k < 4; k++) push(1'b0, 1'b0, pk(-65536, 98304));
        push(1'b1, 1'b0, pk(-131072, 196608));
        push(1'b0, 1'b1, pk(65536, 114688));
        for (int k = 0; k < 5; k++) send(k == 0, 1'b0, pk(65536, 131072));
        send(1'b1, 1'b0, pk(65536, 262144));
        send(1'b0, 1'b1, pk(196608, 131072));
        wait_drain();

        // Reset pulsed mid-line: everything in flight is dropped
        chk_en = 1'b0;
        send(1'b1, 1'b0, pk(65536, 131072));
        send(1'b0, 1'b0, pk(65536, 131072));
        send(1'b0, 1'b0, pk(65536, 131072));
        rst_i = 1'b1;
        #1;
        check("rst_mid_s_ready", 64'(s_ready_o), 64'd0);
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_mid_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_mid_m_sof_eol", 64'({m_sof_o, m_eol_o}), 64'd0);
        check("rst_mid_m_data", 64'(m_data_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_m_valid", 64'(m_valid_o), 64'd0);
        @(negedge clk);
        chk_en = 1'b1;
        push(1'b1, 1'b1, pk(-131072, 65536));
        send(1'b1, 1'b1, pk(0, 131072));
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
